// File: rtl/display_scan_n_if.sv
// display_scan_n_if: load/data/brightness controls and segment/digit outputs of display_scan_n
interface display_scan_n_if #(parameter int NUM_DIGITS = 4);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [2:0]              bright;
  logic [6:0]              seg_l;
  logic                    dp_l;
  logic [NUM_DIGITS-1:0]   dig;
  logic                    pend;
  logic                    frame;
  modport master (output en, load, data_in, dp_in, bright, input seg_l, dp_l, dig, pend, frame);
  modport slave  (input en, load, data_in, dp_in, bright, output seg_l, dp_l, dig, pend, frame);
endinterface

// File: rtl/display_scan_n.sv
// display_scan_n: N-digit multiplexed 7-seg driver with frame-synchronous double buffering; DISPLAY_LZB_EN enables leading-zero blanking
module display_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PRE_W      = 4
) (
  input logic          clk,
  input logic          rst,
  display_scan_n_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic [4*NUM_DIGITS-1:0] sh_data, act_data;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, lz;
  logic [PRE_W-1:0]        slot_cnt;
  logic [IW-1:0]           dig_idx;
  logic                    boundary, xfer, gate;
  logic [3:0]              nib;
  logic [6:0]              glyph;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef DISPLAY_LZB_EN
  logic run;
  // blank digit k>0 when it and every higher nibble of the displayed value are zero
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      run   = run & (act_data[4*k +: 4] == 4'h0);
      lz[k] = run;
    end
  end
`else
  assign lz = '0;
`endif

  // frame boundary, shadow-to-active transfer, digit gate and glyph for the current slot
  always_comb begin
    boundary = (slot_cnt == '1) && (dig_idx == LAST);
    xfer     = bus.pend && !bus.load && (!bus.en || boundary);
    gate     = (slot_cnt != '0) && (slot_cnt[PRE_W-1 -: 3] <= bus.bright);
    nib      = act_data[{dig_idx, 2'b00} +: 4];
    glyph    = lz[dig_idx] ? 7'h00 : hex7(nib);
  end

  // shadow capture, active transfer and pending/frame flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_data   <= '0;
      sh_dp     <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      bus.pend  <= 1'b0;
      bus.frame <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_data <= bus.data_in;
        sh_dp   <= bus.dp_in;
      end
      if (xfer) begin
        act_data <= sh_data;
        act_dp   <= sh_dp;
      end
      bus.pend  <= bus.load | (bus.pend & ~xfer);
      bus.frame <= bus.en & boundary;
    end
  end

  // slot and digit counters; held at zero while disabled so scanning restarts at digit 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      slot_cnt <= bus.en ? slot_cnt + 1'b1 : '0;
      dig_idx  <= !bus.en ? '0 : slot_cnt != '1 ? dig_idx : dig_idx == LAST ? '0 : dig_idx + 1'b1;
    end
  end

  // registered pin drivers; segments stay on for the whole slot, only dig is gated
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.seg_l <= 7'h7F;
      bus.dp_l  <= 1'b1;
      bus.dig   <= '0;
    end else begin
      bus.seg_l <= bus.en ? ~glyph : 7'h7F;
      bus.dp_l  <= ~(bus.en & act_dp[dig_idx]);
      bus.dig   <= (bus.en && gate) ? NUM_DIGITS'(1) << dig_idx : '0;
    end
  end
endmodule

// File: doc/display_scan_n.md
# display_scan_n

Parametrised multi-digit, multiplexed seven-segment display driver that succeeds the fixed four-digit driver. It does the following:
- accepts a packed hex value and decimal-point mask through a load strobe;
- double-buffers the load so new data takes effect only at a frame boundary, which prevents tearing;
- scans N common-anode digits with programmable dead-time and 8-level brightness;
- drives active-low segment lines directly to board pins.

## Interface
- NUM_DIGITS, 4: number of scanned digits (1..16).
- PRE_W, 4: slot counter width; each digit slot lasts 2^PRE_W clocks; PRE_W >= 3.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- en  in  1  scan enable; 0 blanks all outputs.
- load  in  1  single-cycle strobe; captures data_in and dp_in into the shadow register.
- data_in  in  4*NUM_DIGITS  hex digits; nibble k (bits 4k+3:4k) is shown on digit k; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- bright  in  3  brightness; 7 = maximum, 0 = minimum (still visible).
- seg_l  out  7  segments a..g on bits 0..6, active-low.
- dp_l  out  1  decimal point, active-low.
- dig  out  NUM_DIGITS  digit enables, active-high, at most one high.
- pend  out  1  shadow data is waiting for the next frame boundary.
- frame  out  1  one-cycle pulse when a frame boundary is crossed.

## Operation
- Registers:
  - shadow (data and dp);
  - active (data and dp);
  - slot_cnt (PRE_W bits);
  - dig_idx (ceil(log2 NUM_DIGITS) bits, minimum 1).
- Reset (rst=0 at a clk edge) sets:
  - seg_l = 7'h7F, dp_l = 1;
  - dig = 0, pend = 0, frame = 0;
  - all counters, shadow and active registers to 0.
- Load:
  - load=1 writes the shadow register and sets pend.
  - A load while pend=1 overwrites the shadow register. The last load wins, and no error is raised.
- Transfer from shadow to active:
  - When en=1: at the frame boundary, i.e. the cycle where slot_cnt = 2^PRE_W-1 and dig_idx = NUM_DIGITS-1. pend clears on that cycle.
  - When en=0: on the cycle after pend is set.
  - load on the boundary cycle itself: the new data is not transferred at that boundary. It goes at the next boundary, and pend stays 1.
- Scanning, while en=1:
  - slot_cnt increments every cycle.
  - On slot_cnt wrap, dig_idx increments, and wraps from NUM_DIGITS-1 to 0.
  - frame pulses on the cycle after the boundary.
- en=0:
  - slot_cnt and dig_idx clear to 0 and hold there.
  - Outputs are blanked: seg_l = 7F, dp_l = 1, dig = 0.
  - On re-enable, scanning starts at digit 0, slot 0.
- Digit enable: dig[dig_idx] is high only when both of these hold:
  - slot_cnt != 0 (one-clock dead time to prevent ghosting);
  - slot_cnt[PRE_W-1:PRE_W-3] <= bright.
- Segment and dp outputs:
  - seg_l is the hex decode of the active nibble at dig_idx. Glyphs 0-9, A, b, C, d, E, F. Patterns are active-high, e.g. 0 = 3F, 1 = 06, 8 = 7F, A = 77, F = 71; seg_l is their inverse.
  - dp_l = ~active dp bit at dig_idx.
  - Segments are driven for the whole slot; only dig is gated.

## Timing
- All outputs are registered. They reflect the counter state of the previous cycle (1-cycle latency).
- After reset release with en=1: the first dig[0] assertion is at cycle 2 (slot_cnt=1, plus register latency).
- Slot = 2^PRE_W cycles; frame = NUM_DIGITS * 2^PRE_W cycles.
- On-time per slot = min(2^PRE_W-1, (bright+1) * 2^(PRE_W-3) minus 1 if it includes slot 0).
- Load to visible display:
  - en=1: at most one frame plus 2 cycles.
  - en=0: active updates 1 cycle after load, but nothing is visible until en returns to 1.
- Reset mid-frame: the next edge gives the reset values. Pending shadow data is discarded.
- bright changes take effect on the next cycle, without waiting for a frame boundary.

## Configuration
- DISPLAY_LZB_EN, when defined, enables leading-zero blanking:
  - A digit k > 0 is blanked (seg_l = 7F) if its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - dp_l still follows dp_in, and dig still scans.
  - The blank mask is computed from the active register.
- Undefined: every digit shows its nibble, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS=4, PRE_W=4, bright=7.
- Reset: hold rst=0 for 3 clocks with en=1 -> seg_l=7F, dp_l=1, dig=0, pend=0 on every cycle.
- Scan: en=1, load data_in=16'h1234, dp_in=4'b0100 ->
  - after the boundary, dig cycles 0001, 0010, 0100, 1000, 16 clocks each, with 1 dead clock per slot;
  - seg_l is ~66 (digit 4) during dig[0] and ~4F (digit 3) during dig[1];
  - dp_l=0 only during dig[2].
- Double buffer: mid-frame load 16'hABCD, then load 16'h5678 ->
  - pend=1 until the boundary;
  - the frame in progress still shows 1234;
  - the next frame shows 5678, and frame pulses once.
- Brightness: bright=0 -> dig[k] is high for exactly 1 clock per slot (slot_cnt=1). bright=3 -> high for 7 clocks.
- Enable gating: deassert en mid-slot -> next cycle dig=0 and seg_l=7F. Reassert en -> dig[0] is high 2 cycles later.
- LZB (macro defined): load 16'h0070 -> digits 3 and 2 show seg_l=7F, digit 1 shows ~07, digit 0 shows ~3F. Without the macro, digits 3 and 2 show ~3F.
